// File: rtl/serial_bit_feeder.sv
// ============================================================================
// Module   : serial_bit_feeder
// Purpose  : Serializes valid/ready parallel words onto one bit line, one word
//            of buffering so consecutive words stream with no gap bits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_bit_feeder #(
  parameter int          DATA_W    = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0,
  parameter int          CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic              dout,
  output logic              dout_valid,
  output logic              busy,
  output logic [CNT_W-1:0]  words_sent
);

  localparam int                 CNT_BW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_BW-1:0]  c_last = CNT_BW'(DATA_W - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_hold;
  logic                r_hold_full;
  logic [DATA_W-1:0]   r_shift;
  logic [CNT_BW-1:0]   r_bit_cnt;
  logic                r_dout;
  logic                r_dout_valid;
  logic [CNT_W-1:0]    r_words;

  logic                w_accept;
  logic                w_last;
  logic                w_load;
  logic                w_first;
  logic                w_next_bit;
  logic [DATA_W-1:0]   w_shifted;

  // The shifter rotates rather than shifts so every bit of r_shift stays live;
  // only the bits not yet presented are ever read.
  generate
    if (MSB_FIRST) begin : g_msb
      assign w_first    = r_hold[DATA_W-1];
      assign w_next_bit = r_shift[DATA_W-2];
      assign w_shifted  = {r_shift[DATA_W-2:0], r_shift[DATA_W-1]};
    end else begin : g_lsb
      assign w_first    = r_hold[0];
      assign w_next_bit = r_shift[1];
      assign w_shifted  = {r_shift[0], r_shift[DATA_W-1:1]};
    end
  endgenerate

  assign in_ready   = !r_hold_full && !flush;
  assign w_accept   = in_valid && in_ready;
  assign w_last     = (r_state == S_SHIFT) && (r_bit_cnt == c_last);
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign busy       = (r_state == S_SHIFT) || r_hold_full;
  assign words_sent = r_words;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_hold_full) begin
            w_load      = 1'b1;
            w_state_nxt = S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_last) begin
            if (r_hold_full) begin
              w_load = 1'b1;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Accept and load never coincide: accept needs an empty holding register,
  // load needs a full one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold       <= '0;
      r_hold_full  <= 1'b0;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_dout       <= IDLE_BIT;
      r_dout_valid <= 1'b0;
      r_words      <= '0;
    end else if (flush) begin
      r_hold_full  <= 1'b0;
      r_bit_cnt    <= '0;
      r_dout       <= IDLE_BIT;
      r_dout_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_hold      <= in_data;
        r_hold_full <= 1'b1;
      end
      if (w_load) begin
        r_shift      <= r_hold;
        r_hold_full  <= 1'b0;
        r_bit_cnt    <= '0;
        r_dout       <= w_first;
        r_dout_valid <= 1'b1;
      end else if (w_last) begin
        r_dout       <= IDLE_BIT;
        r_dout_valid <= 1'b0;
      end else if (r_state == S_SHIFT) begin
        r_shift   <= w_shifted;
        r_bit_cnt <= r_bit_cnt + 1'b1;
        r_dout    <= w_next_bit;
      end
      if (w_last) begin
        r_words <= r_words + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/serial_bit_feeder.md
Name: serial_bit_feeder

Overview:
- Upstream stage for the serial "1010" Moore sequence detector.
- Accepts parallel words over a valid/ready handshake and serializes them onto a single bit line, one bit per clock. This line drives the detector's din.
- A one-word holding register allows back-to-back words to stream with no gap bits.
- Reports whether the serial line is carrying data and counts words fully shifted out.

Parameters:
- DATA_W, 8, width of each parallel input word (legal range 2..32).
- MSB_FIRST, 1, 1 = shift out bit DATA_W-1 first; 0 = bit 0 first.
- IDLE_BIT, 0, level driven on dout whenever no word is being shifted.
- CNT_W, 16, width of the words_sent counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_data  input  DATA_W  parallel word to serialize.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  feeder can accept a word this cycle.
- flush  input  1  synchronous clear of buffered and in-flight data.
- dout  output  1  serial bit to the detector (registered).
- dout_valid  output  1  dout carries a data bit, not idle fill (registered).
- busy  output  1  shifter or holding register occupied.
- words_sent  output  CNT_W  count of words fully shifted out.

Behaviour:
- Reset (reset_n low, asynchronous): state = IDLE, hold_full = 0, bit_cnt = 0, dout = IDLE_BIT, dout_valid = 0, in_ready = 1, busy = 0, words_sent = 0. Outputs hold these values while reset_n is low.
- Internal state: hold_reg/hold_full (one-word buffer), shift_reg, bit_cnt (counts 0..DATA_W-1), FSM with states IDLE and SHIFT.
- in_ready = !hold_full && !flush (combinational).
- Accept: in_valid && in_ready at a rising edge writes in_data into hold_reg and sets hold_full.
- IDLE -> SHIFT: at a rising edge in IDLE with hold_full = 1:
  - shift_reg <= hold_reg, hold_full <= 0, bit_cnt <= 0.
  - dout <= first bit, dout_valid <= 1.
- Latency: a word accepted at edge E0 shows its first bit on dout after E1. Bit k is presented during the cycle after edge E1+k, for k = 0..DATA_W-1.
- SHIFT, bit_cnt < DATA_W-1: each edge presents the next bit and increments bit_cnt.
- SHIFT, bit_cnt = DATA_W-1 (last bit on dout): the next edge increments words_sent (wraps modulo 2^CNT_W). Then:
  - if hold_full = 1: load the next word exactly as IDLE -> SHIFT, with no gap cycle; dout_valid stays 1.
  - else: go to IDLE, dout <= IDLE_BIT, dout_valid <= 0.
- Same edge as a hold -> shifter transfer: an accept cannot coincide, because in_ready was low while hold_full = 1. in_ready rises in the cycle after the transfer.
- Streaming without gaps: the producer must present the next word within DATA_W-1 cycles after in_ready rises.
- busy = (state == SHIFT) || hold_full.
- flush (synchronous, highest priority after reset):
  - at the edge: state <= IDLE, hold_full <= 0, dout <= IDLE_BIT, dout_valid <= 0.
  - words_sent is unchanged, including for a partially sent word.
  - in_data is not accepted in a flush cycle.
- Reset mid-word: all state is lost immediately; no residual bits are emitted after reset_n rises.
- The bit order within a word is fixed at load time; MSB_FIRST selects the shift direction.
- dout is driven every cycle. The downstream detector samples it every clock with no valid, so idle cycles deliver IDLE_BIT into the detector.

Test Plan:
- Reset: assert reset_n low mid-stream -> next cycle dout = 0, dout_valid = 0, in_ready = 1, busy = 0, words_sent = 0.
- Single word, DATA_W=8, MSB_FIRST=1, in_data = 0x0A accepted at E0 -> dout = 0,0,0,0,1,0,1,0 after E1..E8, with dout_valid = 1 on those 8 cycles only. Idle 0 follows from E9; words_sent = 1 after E9. The downstream detector asserts dout = 1 during the cycle after its state reaches s4.
- Back-to-back: 0xAA, then 0x55 presented while in_ready is high -> 16 contiguous valid bits 1010101001010101 with no gap. in_ready is low from E0+1 until the first transfer, then low again until the second transfer. words_sent = 2.
- LSB_FIRST (MSB_FIRST=0), in_data = 0x50 -> bits 0,0,0,0,1,0,1,0.
- Flush after the 3rd bit of 0xF0, with 0x0F held -> next cycle dout_valid = 0, dout = IDLE_BIT, busy = 0, words_sent unchanged. The next accepted word starts cleanly from its first bit.
- Counter wrap, CNT_W=4: send 17 words -> words_sent = 1.
